// File: rtl/camera_capture.sv
// camera_capture: turns an 8-bit DVP-style camera byte stream (PCLK domain) into RGB565 pixels.
//
// Ports:
//   clk          camera PCLK, the only clock
//   rst          asynchronous active-high reset
//   init_finish  camera-configured flag, asynchronous, double-synchronized here
//   vsync        frame boundary pulse (high between frames)
//   href         high while line bytes are valid
//   d            camera data byte
//   pixel_data   assembled pixel, first byte of the pair in [15:8]
//   pixel_valid  one-cycle strobe qualifying pixel_data / pixel_addr
//   pixel_addr   line*H_PIXELS + column of the strobed pixel
//   frame_done   high whenever no frame capture is in progress
//   frame_end    one-cycle pulse when a captured frame completes
//   line_err     sticky: odd byte count or pixel/line overrun seen
module camera_capture #(
    parameter int unsigned H_PIXELS   = 640,
    parameter int unsigned V_LINES    = 480,
    parameter int unsigned ADDR_WIDTH = 19
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  init_finish,
    input  logic                  vsync,
    input  logic                  href,
    input  logic [7:0]            d,
    output logic [15:0]           pixel_data,
    output logic                  pixel_valid,
    output logic [ADDR_WIDTH-1:0] pixel_addr,
    output logic                  frame_done,
    output logic                  frame_end,
    output logic                  line_err
);

    // Counters carry one extra value so "full" (H_PIXELS / V_LINES) is representable.
    localparam int unsigned ColW  = $clog2(H_PIXELS + 1);
    localparam int unsigned LineW = $clog2(V_LINES + 1);
    localparam logic [ColW-1:0]       HMax  = ColW'(H_PIXELS);
    localparam logic [LineW-1:0]      LMax  = LineW'(V_LINES);
    localparam logic [ADDR_WIDTH-1:0] HStep = ADDR_WIDTH'(H_PIXELS);

    typedef enum logic [1:0] {StIdle, StWaitVs, StCapture} state_e;

    state_e                state_q, state_d;
    logic                  init_s1_q, init_s2_q;
    logic                  vsync_q, vsync_prev_q;
    logic                  href_q, href_prev_q;
    logic [7:0]            d_q;
    logic                  phase_q, phase_d;
    logic [7:0]            hi_byte_q, hi_byte_d;
    logic [ColW-1:0]       col_q, col_d;
    logic [LineW-1:0]      line_q, line_d;
    logic [ADDR_WIDTH-1:0] row_base_q, row_base_d;
    logic [15:0]           pixel_data_q, pixel_data_d;
    logic                  pixel_valid_q, pixel_valid_d;
    logic [ADDR_WIDTH-1:0] pixel_addr_q, pixel_addr_d;
    logic                  frame_end_q, frame_end_d;
    logic                  line_err_q, line_err_d;

    logic vs_fall, vs_rise, href_fall;

    // Edges are taken between the registered copy and its one-cycle-older copy.
    assign vs_fall   = vsync_prev_q & ~vsync_q;
    assign vs_rise   = ~vsync_prev_q & vsync_q;
    assign href_fall = href_prev_q & ~href_q;

    always_comb begin
        state_d       = state_q;
        phase_d       = phase_q;
        hi_byte_d     = hi_byte_q;
        col_d         = col_q;
        line_d        = line_q;
        row_base_d    = row_base_q;
        pixel_data_d  = pixel_data_q;
        pixel_valid_d = 1'b0;
        pixel_addr_d  = pixel_addr_q;
        frame_end_d   = 1'b0;
        line_err_d    = line_err_q;

        if (!init_s2_q) begin
            // Losing configuration aborts silently: no frame_end.
            state_d = StIdle;
            phase_d = 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    state_d    = StWaitVs;
                    line_err_d = 1'b0;
                end
                StWaitVs: begin
                    if (vs_fall) begin
                        state_d      = StCapture;
                        col_d        = '0;
                        line_d       = '0;
                        row_base_d   = '0;
                        pixel_addr_d = '0;
                        phase_d      = 1'b0;
                    end
                end
                StCapture: begin
                    if (vs_rise) begin
                        // Any half-assembled pixel is dropped here.
                        state_d     = StWaitVs;
                        frame_end_d = 1'b1;
                        phase_d     = 1'b0;
                    end else if (href_q) begin
                        if (!phase_q) begin
                            hi_byte_d = d_q;
                            phase_d   = 1'b1;
                        end else begin
                            phase_d = 1'b0;
                            if ((col_q < HMax) && (line_q < LMax)) begin
                                pixel_data_d  = {hi_byte_q, d_q};
                                pixel_valid_d = 1'b1;
                                pixel_addr_d  = row_base_q + ADDR_WIDTH'(col_q);
                                col_d         = col_q + ColW'(1);
                            end else begin
                                line_err_d = 1'b1;
                            end
                        end
                    end else if (href_fall) begin
                        if (phase_q) begin
                            phase_d    = 1'b0;
                            line_err_d = 1'b1;
                        end
                        col_d = '0;
                        // Only lines that produced pixels advance; line_q saturates at V_LINES.
                        if ((col_q != '0) && (line_q < LMax)) begin
                            line_d     = line_q + LineW'(1);
                            row_base_d = row_base_q + HStep;
                        end
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= StIdle;
            init_s1_q     <= 1'b0;
            init_s2_q     <= 1'b0;
            vsync_q       <= 1'b0;
            vsync_prev_q  <= 1'b0;
            href_q        <= 1'b0;
            href_prev_q   <= 1'b0;
            d_q           <= '0;
            phase_q       <= 1'b0;
            hi_byte_q     <= '0;
            col_q         <= '0;
            line_q        <= '0;
            row_base_q    <= '0;
            pixel_data_q  <= '0;
            pixel_valid_q <= 1'b0;
            pixel_addr_q  <= '0;
            frame_end_q   <= 1'b0;
            line_err_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            init_s1_q     <= init_finish;
            init_s2_q     <= init_s1_q;
            vsync_q       <= vsync;
            vsync_prev_q  <= vsync_q;
            href_q        <= href;
            href_prev_q   <= href_q;
            d_q           <= d;
            phase_q       <= phase_d;
            hi_byte_q     <= hi_byte_d;
            col_q         <= col_d;
            line_q        <= line_d;
            row_base_q    <= row_base_d;
            pixel_data_q  <= pixel_data_d;
            pixel_valid_q <= pixel_valid_d;
            pixel_addr_q  <= pixel_addr_d;
            frame_end_q   <= frame_end_d;
            line_err_q    <= line_err_d;
        end
    end

    assign pixel_data  = pixel_data_q;
    assign pixel_valid = pixel_valid_q;
    assign pixel_addr  = pixel_addr_q;
    assign frame_done  = (state_q != StCapture);
    assign frame_end   = frame_end_q;
    assign line_err    = line_err_q;

endmodule

// File: doc/camera_capture.md
CAMERA_CAPTURE -- requirements
Module: camera_capture

Interface
REQ-001 SHALL have parameter H_PIXELS, default 640, pixels per line.
REQ-002 SHALL have parameter V_LINES, default 480, lines per frame.
REQ-003 SHALL have parameter ADDR_WIDTH, default 19, pixel address width; ADDR_WIDTH >= clog2(H_PIXELS*V_LINES).
REQ-004 clk  input  1  camera PCLK; the only clock; all logic on its rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 init_finish  input  1  camera-configured flag from the initialization stage; asynchronous to clk.
REQ-007 vsync  input  1  camera VSYNC, high pulse marks frame boundary.
REQ-008 href  input  1  camera HREF, high while line bytes are valid.
REQ-009 d  input  8  camera data byte.
REQ-010 pixel_data  output  16  assembled RGB565 pixel, first byte in [15:8].
REQ-011 pixel_valid  output  1  one-cycle strobe qualifying pixel_data/pixel_addr.
REQ-012 pixel_addr  output  ADDR_WIDTH  linear address, line*H_PIXELS+column.
REQ-013 frame_done  output  1  level, high whenever no frame capture is in progress; feeds the initialization stage.
REQ-014 frame_end  output  1  one-cycle pulse at completion of a captured frame.
REQ-015 line_err  output  1  sticky flag, odd byte count or pixel/line overrun seen.

Function
REQ-016 init_finish SHALL pass through a 2-flop synchronizer before use; vsync, href, d SHALL be registered once before use.
REQ-017 FSM states SHALL be IDLE, WAIT_VS, CAPTURE.
REQ-018 IDLE: frame_done=1; go to WAIT_VS when synchronized init_finish=1.
REQ-019 WAIT_VS: frame_done=1; go to CAPTURE on registered vsync falling edge; clear column, line, address, byte phase.
REQ-020 CAPTURE: frame_done=0; on registered vsync rising edge pulse frame_end one cycle and return to WAIT_VS.
REQ-021 Synchronized init_finish=0 in any state SHALL force IDLE next cycle with no frame_end pulse.
REQ-022 In CAPTURE with registered href=1, bytes SHALL alternate phase: phase 0 latches byte to [15:8], phase 1 completes pixel.
REQ-023 Pixel completion at edge k SHALL set pixel_valid=1 for exactly the cycle after edge k; latency from raw byte at pin to strobe = 2 edges.
REQ-024 pixel_addr SHALL increment by 1 after each emitted pixel and never exceed H_PIXELS*V_LINES-1.
REQ-025 Column counter SHALL reset on registered href falling edge; line counter SHALL increment on that edge if column>0.
REQ-026 href falling with phase 1 pending (odd byte count) SHALL drop the partial byte, reset phase, set line_err.
REQ-027 Pixels beyond H_PIXELS in a line, or lines beyond V_LINES, SHALL be discarded (no strobe, no address change) and set line_err.
REQ-028 vsync rising mid-pixel SHALL drop the partial byte; frame_end still pulses.
REQ-029 line_err SHALL clear only on rst or entry to WAIT_VS from IDLE.

Reset
REQ-030 rst=1 SHALL immediately set: state IDLE, pixel_data=0, pixel_valid=0, pixel_addr=0, frame_done=1, frame_end=0, line_err=0, synchronizer and input registers 0.
REQ-031 rst deasserted mid-frame SHALL wait for next vsync falling edge before capturing.

Verification
REQ-032 init_finish=0, camera frames running -> no pixel_valid, frame_done=1 throughout.
REQ-033 H_PIXELS=4,V_LINES=2, one frame bytes 0x12,0x34,... -> 8 strobes, first pixel_data=0x1234 addr 0, last addr 7, one frame_end, line_err=0.
REQ-034 Line with 7 bytes -> 3 pixels emitted, line_err=1, next line starts at column 0.
REQ-035 Line with 12 bytes at H_PIXELS=4 -> 4 pixels, addresses 0..3, line_err=1.
REQ-036 init_finish dropped mid-frame -> IDLE within 3 cycles, no frame_end, frame_done=1.
REQ-037 rst asserted asynchronously during CAPTURE -> all outputs at reset values before next clk edge.
